// File: rtl/bfp_shift_ctrl_if.sv
// Stream interface for the block-floating-point shift controller.
// The slave modport is the controller's view; the master modport is the
// view of whoever feeds samples in and consumes shifted-frame samples out.
interface bfp_shift_ctrl_if #(
  parameter int DATA_W  = 7,
  parameter int SHIFT_W = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [DATA_W-1:0]  in_x;
  logic               out_valid;
  logic               out_ready;
  logic [DATA_W-1:0]  out_x;
  logic [SHIFT_W-1:0] out_shift;
  logic               out_last;

  modport slave (
    input  in_valid,
    input  in_x,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_x,
    output out_shift,
    output out_last
  );

  modport master (
    output in_valid,
    output in_x,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_x,
    input  out_shift,
    input  out_last
  );
endinterface

// File: rtl/bfp_shift_ctrl.sv
// Block-floating-point normalisation controller.
// Buffers one frame of signed samples, tracks the OR of their magnitude
// bits, and replays the frame with the common left shift that normalises
// the largest-magnitude sample.
//
// Optional feature: define BFP_HEADROOM_EN to reserve one bit of headroom
// (final shift = max(shift-1, 0)).
//
// state | meaning
// ------+----------------------------------------------------------
// FILL  | accepting samples into the frame buffer, in_ready=1
// DRAIN | replaying buffered frame with shift attached, out_valid=1
module bfp_shift_ctrl #(
  parameter int DATA_W    = 7,
  parameter int SHIFT_W   = 4,
  parameter int FRAME_LEN = 8,
  parameter int CNT_W     = 3
) (
  input  logic            clk_i,
  input  logic            rst,
  bfp_shift_ctrl_if.slave bus
);

  typedef enum logic [0:0] {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

  state_t             state;
  logic [CNT_W-1:0]   wr_cnt;
  logic [CNT_W-1:0]   rd_cnt;
  logic [CNT_W-1:0]   rd_cnt_inc;
  // Only the magnitude bits are kept: the XOR with the sign always clears the MSB.
  logic [DATA_W-2:0]  acc;
  logic [DATA_W-2:0]  acc_next;
  logic [SHIFT_W-1:0] shift_q;
  logic [SHIFT_W-1:0] shift_next;
  logic [DATA_W-1:0]  frame_mem [FRAME_LEN];

  logic               in_ready_q;
  logic               out_valid_q;
  logic [DATA_W-1:0]  out_x_q;
  logic [SHIFT_W-1:0] out_shift_q;
  logic               out_last_q;

  logic               in_fire;
  logic               out_fire;

  // Redundant-sign count of the accumulated magnitude bits, saturated at
  // DATA_W-1 for an all-zero / all-minus-one frame. Direction bit forced 0.
  function automatic logic [SHIFT_W-1:0] calc_shift(input logic [DATA_W-2:0] a);
    int lz;
    lz = DATA_W - 1;
    // Ascending scan so the highest set bit is the last one to win.
    for (int i = 0; i <= DATA_W - 2; i++) begin
      if (a[i]) lz = DATA_W - 2 - i;
    end
`ifdef BFP_HEADROOM_EN
    if (lz > 0) lz = lz - 1;
`endif
    return {1'b0, lz[SHIFT_W-2:0]};
  endfunction

  assign in_fire    = bus.in_valid && in_ready_q;
  assign out_fire   = out_valid_q && bus.out_ready;
  assign rd_cnt_inc = rd_cnt + CNT_W'(1);

  // Accumulator including the sample being accepted, so the final sample
  // of the frame contributes to the shift computed on the same edge.
  always_comb begin
    acc_next   = acc | (bus.in_x[DATA_W-2:0] ^ {(DATA_W-1){bus.in_x[DATA_W-1]}});
    shift_next = calc_shift(acc_next);
  end

  // Frame storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk_i) begin
    if (in_fire) begin
      frame_mem[wr_cnt] <= bus.in_x;
    end
  end

  // Control FSM with registered handshake and output signals.
  always_ff @(posedge clk_i) begin
    if (rst) begin
      state       <= FILL;
      wr_cnt      <= '0;
      rd_cnt      <= '0;
      acc         <= '0;
      shift_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_x_q     <= '0;
      out_shift_q <= '0;
      out_last_q  <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (in_fire) begin
            acc    <= acc_next;
            wr_cnt <= wr_cnt + CNT_W'(1);
            if (wr_cnt == LAST_IDX) begin
              // Frame complete: present the first sample on the next cycle.
              wr_cnt      <= '0;
              shift_q     <= shift_next;
              state       <= DRAIN;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
              out_x_q     <= frame_mem[0];
              out_shift_q <= shift_next;
              out_last_q  <= (LAST_IDX == '0);
            end
          end
        end

        DRAIN: begin
          if (out_fire) begin
            if (rd_cnt == LAST_IDX) begin
              rd_cnt      <= '0;
              acc         <= '0;
              state       <= FILL;
              in_ready_q  <= 1'b1;
              out_valid_q <= 1'b0;
              out_x_q     <= '0;
              out_shift_q <= '0;
              out_last_q  <= 1'b0;
            end else begin
              rd_cnt      <= rd_cnt_inc;
              out_x_q     <= frame_mem[rd_cnt_inc];
              out_shift_q <= shift_q;
              out_last_q  <= (rd_cnt_inc == LAST_IDX);
            end
          end
        end

        default: begin
          state       <= FILL;
          wr_cnt      <= '0;
          rd_cnt      <= '0;
          acc         <= '0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          out_x_q     <= '0;
          out_shift_q <= '0;
          out_last_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_x     = out_x_q;
  assign bus.out_shift = out_shift_q;
  assign bus.out_last  = out_last_q;

endmodule

// File: doc/bfp_shift_ctrl.md
Name: bfp_shift_ctrl

Overview:
- Block-floating-point normalisation controller, directly upstream of the registered bidirectional shifter stage.
- Buffers one frame of signed samples and finds the common shift that normalises the largest-magnitude sample.
- Replays the frame with that shift attached to every sample, so the shifter receives aligned in_x / shift_mag pairs.
- Valid/ready stream on both sides; single frame buffer.

Parameters:
DATA_W, 7, sample width (signed two's complement); must match shifter in_x width
SHIFT_W, 4, shift field width; MSB is direction bit, always 0 (left/normalise) from this block
FRAME_LEN, 8, samples per frame; power of two, 2..64
CNT_W, 3, log2(FRAME_LEN)

Ports:
clk_i  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  input sample valid
in_ready  out  1  block can accept a sample
in_x  in  DATA_W  signed input sample
out_valid  out  1  output sample valid
out_ready  in  1  downstream accepts output
out_x  out  DATA_W  buffered sample (unmodified)
out_shift  out  SHIFT_W  frame shift amount, drives shifter shift_mag
out_last  out  1  high with final sample of frame

Behaviour:
- Reset:
  - Sampled on clk_i rising edge while rst=1.
  - state=FILL, wr_cnt=rd_cnt=0, acc=0, shift_q=0.
  - Outputs: in_ready=1, out_valid=0, out_x=0, out_shift=0, out_last=0.
  - Reset mid-frame (either state) discards the partial or undrained frame; no output is emitted afterwards.
- Handshake:
  - Transfer happens on a cycle with valid&&ready.
  - Source holds in_x stable while in_valid=1 and in_ready=0.
  - out_* are held stable while out_valid=1 and out_ready=0.
- FILL (in_ready=1, out_valid=0):
  - On input transfer: buf[wr_cnt]<=in_x; acc<=acc | (in_x ^ {DATA_W{in_x[DATA_W-1]}}); wr_cnt++.
  - On the transfer with wr_cnt==FRAME_LEN-1:
    - wr_cnt wraps to 0.
    - shift_q <= redundant-sign count computed from the updated acc, including this final sample.
    - Next state DRAIN.
- Shift computation:
  - shift = number of leading zeros in acc[DATA_W-2:0], saturated at DATA_W-1.
  - An all-zero or all-minus-one frame gives DATA_W-1 = 6.
  - out_shift = {1'b0, shift[SHIFT_W-2:0]}; direction bit is always 0.
  - Guarantee: every sample << shift still fits in DATA_W signed.
- DRAIN (in_ready=0, out_valid=1):
  - out_x=buf[rd_cnt]; out_shift=shift_q; out_last=(rd_cnt==FRAME_LEN-1).
  - On output transfer: rd_cnt++.
  - On the last transfer: rd_cnt wraps to 0, acc<=0, next state FILL.
- Latency:
  - First out_valid is on the cycle after the last input transfer of the frame.
  - With out_ready held at 1, the frame drains in FRAME_LEN consecutive cycles.
  - in_ready returns to 1 on the cycle after the out_last transfer.
  - No input/output overlap: throughput is one frame per 2*FRAME_LEN cycles minimum.
- When out_valid=0: out_x, out_shift and out_last hold 0.
- in_valid during DRAIN is ignored; the sample is not consumed.

Optional Feature:
- Macro BFP_HEADROOM_EN.
- Defined: final shift = max(shift-1, 0), reserving one bit of headroom for downstream accumulation. An all-zero frame yields 5.
- Undefined: full normalisation as above.
- Shift computation is otherwise identical; handshake and timing are unchanged.

Test Plan:
- Reset then frame {3,-2,1,0,0,0,0,0} with out_ready=1:
  - out_shift=4 on all 8 outputs; samples replayed in order.
  - out_last only on the 8th output.
  - First out_valid one cycle after the 8th input transfer.
- Frame of eight 0s -> out_shift=6. Frame of eight -1 (7'h7F) -> out_shift=6. With BFP_HEADROOM_EN: both give 5.
- Frame containing -64 (7'h40) and +63 (7'h3F) -> out_shift=0; with BFP_HEADROOM_EN still 0 (saturates).
- Backpressure:
  - Hold out_ready=0 for 5 cycles mid-drain -> out_x, out_shift, out_last stable; in_ready=0 throughout.
  - No sample lost or duplicated.
- Random in_valid gaps during FILL -> buffer captures only transferred samples; resulting shift matches a reference model over 100 random frames.
- Assert rst for one cycle after 5 samples accepted -> out_valid never rises for that frame; the next full frame produces the correct shift, unaffected by the aborted samples.
